// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and default latencies for the clock-gate enable controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CgOff   = 2'd0,
        CgWake  = 2'd1,
        CgOn    = 2'd2,
        CgDrain = 2'd3
    } cg_state_e;

    localparam int unsigned CgIdleCyclesDef = 16;
    localparam int unsigned CgOnLatencyDef  = 2;
    localparam int unsigned CgOffLatencyDef = 2;

    function automatic int unsigned cg_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Drives en_i of a downstream clock gate: req/ack wake-up, idle timeout,
// and fixed hold-offs covering the gate's CE synchroniser latency.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = CgIdleCyclesDef,
    parameter int unsigned ON_LATENCY  = CgOnLatencyDef,
    parameter int unsigned OFF_LATENCY = CgOffLatencyDef
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       busy_i,
    input  logic       force_on_i,
    output logic       clk_en_o,
    output logic       ack_o,
    output logic       off_o,
    output logic [1:0] state_o
);

    localparam int unsigned CntW = $clog2(cg_max3(IDLE_CYCLES, ON_LATENCY, OFF_LATENCY) + 1);

    localparam logic [CntW-1:0] OnLoad   = CntW'(ON_LATENCY - 1);
    localparam logic [CntW-1:0] OffLoad  = CntW'(OFF_LATENCY - 1);
    localparam logic [CntW-1:0] IdleLast = CntW'(IDLE_CYCLES - 1);
    localparam logic [CntW-1:0] IdleSat  = CntW'(IDLE_CYCLES);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    if (IDLE_CYCLES == 0 || ON_LATENCY == 0 || OFF_LATENCY == 0) begin : g_bad_param
        $error("clk_gate_ctrl: IDLE_CYCLES, ON_LATENCY and OFF_LATENCY must all be >= 1");
    end

    cg_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            clk_en_d, ack_d, off_d;
    logic            wake, active;

    assign wake   = req_i | force_on_i;
    assign active = wake | busy_i;

    // Next state; one counter serves as wake hold-off, idle timer and drain hold-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;

        case (state_q)
            CgOff: begin
                cnt_d = '0;
                if (wake) begin
                    state_d = CgWake;
                    cnt_d   = OnLoad;
                end
            end
            CgWake: begin
                if (cnt_q == '0) begin
                    state_d = CgOn;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            CgOn: begin
                if (active) begin
                    cnt_d = '0;
                end else if (cnt_q >= IdleLast) begin
                    state_d = CgDrain;
                    cnt_d   = OffLoad;
                end else if (cnt_q != IdleSat) begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            CgDrain: begin
                // A wake seen during drain is remembered and honoured once the hold-off ends.
                pend_d = pend_q | wake;
                if (cnt_q == '0) begin
                    pend_d = 1'b0;
                    if (pend_q | wake) begin
                        state_d = CgWake;
                        cnt_d   = OnLoad;
                    end else begin
                        state_d = CgOff;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = CgOff;
                cnt_d   = '0;
            end
        endcase

        clk_en_d = (state_d == CgWake) || (state_d == CgOn);
        ack_d    = (state_d == CgOn);
        off_d    = (state_d == CgOff);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= CgOff;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            clk_en_o <= 1'b0;
            ack_o    <= 1'b0;
            off_o    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            clk_en_o <= clk_en_d;
            ack_o    <= ack_d;
            off_o    <= off_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: default latencies (instance a) and all-ones latencies (instance b).
module tb_clk_gate_ctrl;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAKE  = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req, busy, force_on;
    logic       en_a, ack_a, off_a;
    logic [1:0] st_a;
    logic       en_b, ack_b, off_b;
    logic [1:0] st_b;

    logic sel_b;
    int   cyc;
    int   n_assert = 0;
    int   n_fail   = 0;

    clk_gate_ctrl u_dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .busy_i     (busy),
        .force_on_i (force_on),
        .clk_en_o   (en_a),
        .ack_o      (ack_a),
        .off_o      (off_a),
        .state_o    (st_a)
    );

    clk_gate_ctrl #(
        .IDLE_CYCLES (1),
        .ON_LATENCY  (1),
        .OFF_LATENCY (1)
    ) u_dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .busy_i     (busy),
        .force_on_i (force_on),
        .clk_en_o   (en_b),
        .ack_o      (ack_b),
        .off_o      (off_b),
        .state_o    (st_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk(input string tag, input logic e_en, input logic e_ack,
                       input logic e_off, input logic [1:0] e_st);
        logic [4:0] obs, exp_v;
        obs   = sel_b ? {en_b, ack_b, off_b, st_b} : {en_a, ack_a, off_a, st_a};
        exp_v = {e_en, e_ack, e_off, e_st};
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed en,ack,off,st=%b expected %b", tag, cyc, obs, exp_v);
        end
    endtask

    initial begin
        req = 1'b0; busy = 1'b0; force_on = 1'b0; rst = 1'b1; sel_b = 1'b0; cyc = 0;

        // ---------------- instance a: IDLE=16, ON=2, OFF=2 ----------------
        repeat (3) step();
        chk("a.reset", 1'b0, 1'b0, 1'b1, ST_OFF);
        rst = 1'b0;
        step();
        chk("a.idle_off", 1'b0, 1'b0, 1'b1, ST_OFF);

        // basic req/ack and idle timeout
        req = 1'b1; cyc = -1; step();
        chk("a.t1.wake0", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(1);  chk("a.t1.wake1", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(2);  chk("a.t1.on",    1'b1, 1'b1, 1'b0, ST_ON);
        run_to(10); req = 1'b0;
        run_to(25); chk("a.t1.on25",   1'b1, 1'b1, 1'b0, ST_ON);
        run_to(26); chk("a.t1.drain",  1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(27); chk("a.t1.drain2", 1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(28); chk("a.t1.off",    1'b0, 1'b0, 1'b1, ST_OFF);

        // busy keeps ON alive; busy on the expiry edge still holds ON
        req = 1'b1; cyc = -1; step(); req = 1'b0;
        chk("a.t2.wake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(2);  chk("a.t2.on_nowake", 1'b1, 1'b1, 1'b0, ST_ON);
        for (int p = 1; p <= 4; p++) begin
            run_to(10 * p - 1); busy = 1'b1; step(); busy = 1'b0;
        end
        run_to(35); chk("a.t2.on35", 1'b1, 1'b1, 1'b0, ST_ON);
        run_to(55); chk("a.t2.on55", 1'b1, 1'b1, 1'b0, ST_ON);
        busy = 1'b1; step(); busy = 1'b0;
        chk("a.t2.expiry_hold", 1'b1, 1'b1, 1'b0, ST_ON);
        run_to(71); chk("a.t2.on71", 1'b1, 1'b1, 1'b0, ST_ON);
        run_to(72); chk("a.t2.drain", 1'b0, 1'b0, 1'b0, ST_DRAIN);

        // req during drain: skip OFF, en low exactly OFF_LATENCY cycles
        req = 1'b1; step(); req = 1'b0;
        chk("a.t3.drain_req", 1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(74); chk("a.t3.rewake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(76); chk("a.t3.on",     1'b1, 1'b1, 1'b0, ST_ON);
        run_to(91); chk("a.t3.on91",   1'b1, 1'b1, 1'b0, ST_ON);
        run_to(92); chk("a.t3.drain",  1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(94); chk("a.t3.off",    1'b0, 1'b0, 1'b1, ST_OFF);

        // force_on holds ON
        force_on = 1'b1; cyc = -1; step();
        chk("a.t4.wake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(2);   chk("a.t4.on",    1'b1, 1'b1, 1'b0, ST_ON);
        run_to(50);  chk("a.t4.on50",  1'b1, 1'b1, 1'b0, ST_ON);
        run_to(99);  chk("a.t4.on99",  1'b1, 1'b1, 1'b0, ST_ON);
        force_on = 1'b0;
        run_to(114); chk("a.t4.on114", 1'b1, 1'b1, 1'b0, ST_ON);
        run_to(115); chk("a.t4.drain", 1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(117); chk("a.t4.off",   1'b0, 1'b0, 1'b1, ST_OFF);

        // reset in WAKE and in ON
        req = 1'b1; cyc = -1; step();
        chk("a.t5.wake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        rst = 1'b1; step();
        chk("a.t5.rst_wake", 1'b0, 1'b0, 1'b1, ST_OFF);
        rst = 1'b0;
        run_to(2); chk("a.t5.wake2", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(4); chk("a.t5.on",    1'b1, 1'b1, 1'b0, ST_ON);
        rst = 1'b1; step();
        chk("a.t5.rst_on", 1'b0, 1'b0, 1'b1, ST_OFF);
        rst = 1'b0; req = 1'b0; step();
        chk("a.t5.stay_off", 1'b0, 1'b0, 1'b1, ST_OFF);

        // ---------------- instance b: IDLE=1, ON=1, OFF=1 ----------------
        sel_b = 1'b1;
        rst = 1'b1; repeat (2) step();
        chk("b.reset", 1'b0, 1'b0, 1'b1, ST_OFF);
        rst = 1'b0; step();

        req = 1'b1; cyc = -1; step();
        chk("b.t1.wake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(1);  chk("b.t1.on",    1'b1, 1'b1, 1'b0, ST_ON);
        run_to(10); chk("b.t1.on10",  1'b1, 1'b1, 1'b0, ST_ON);
        req = 1'b0;
        run_to(11); chk("b.t1.drain", 1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(12); chk("b.t1.off",   1'b0, 1'b0, 1'b1, ST_OFF);

        req = 1'b1; cyc = -1; step(); req = 1'b0; busy = 1'b1;
        chk("b.t2.wake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(1);  chk("b.t2.on",   1'b1, 1'b1, 1'b0, ST_ON);
        run_to(20); chk("b.t2.on20", 1'b1, 1'b1, 1'b0, ST_ON);
        busy = 1'b0;
        run_to(21); chk("b.t2.drain", 1'b0, 1'b0, 1'b0, ST_DRAIN);
        req = 1'b1;
        run_to(22); chk("b.t3.rewake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        req = 1'b0;
        run_to(23); chk("b.t3.on",    1'b1, 1'b1, 1'b0, ST_ON);
        run_to(24); chk("b.t3.drain", 1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(25); chk("b.t3.off",   1'b0, 1'b0, 1'b1, ST_OFF);

        force_on = 1'b1; cyc = -1; step();
        chk("b.t4.wake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(1);   chk("b.t4.on",   1'b1, 1'b1, 1'b0, ST_ON);
        run_to(99);  chk("b.t4.on99", 1'b1, 1'b1, 1'b0, ST_ON);
        force_on = 1'b0;
        run_to(100); chk("b.t4.drain", 1'b0, 1'b0, 1'b0, ST_DRAIN);
        run_to(101); chk("b.t4.off",   1'b0, 1'b0, 1'b1, ST_OFF);

        req = 1'b1; cyc = -1; step();
        chk("b.t5.wake", 1'b1, 1'b0, 1'b0, ST_WAKE);
        rst = 1'b1; step();
        chk("b.t5.rst_wake", 1'b0, 1'b0, 1'b1, ST_OFF);
        rst = 1'b0;
        run_to(2); chk("b.t5.wake2", 1'b1, 1'b0, 1'b0, ST_WAKE);
        run_to(3); chk("b.t5.on",    1'b1, 1'b1, 1'b0, ST_ON);
        rst = 1'b1; step();
        chk("b.t5.rst_on", 1'b0, 1'b0, 1'b1, ST_OFF);
        rst = 1'b0; req = 1'b0; step();
        chk("b.t5.stay_off", 1'b0, 1'b0, 1'b1, ST_OFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
